// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the MIPS control units: FSM states, opcode/funct fields,
// ALU control codes and datapath mux selects.
package mips_ctrl_pkg;

   localparam logic [3:0] ST_FETCH    = 4'd0;
   localparam logic [3:0] ST_DECODE   = 4'd1;
   localparam logic [3:0] ST_MEMADR   = 4'd2;
   localparam logic [3:0] ST_MEMREAD  = 4'd3;
   localparam logic [3:0] ST_MEMWB    = 4'd4;
   localparam logic [3:0] ST_MEMWRITE = 4'd5;
   localparam logic [3:0] ST_EXECUTE  = 4'd6;
   localparam logic [3:0] ST_ALUWB    = 4'd7;
   localparam logic [3:0] ST_BRANCH   = 4'd8;
   localparam logic [3:0] ST_IMMEX    = 4'd9;
   localparam logic [3:0] ST_IMMWB    = 4'd10;
   localparam logic [3:0] ST_JUMP     = 4'd11;
   localparam logic [3:0] ST_TRAP     = 4'd12;

   typedef enum logic [3:0] {
      FETCH    = ST_FETCH,
      DECODE   = ST_DECODE,
      MEMADR   = ST_MEMADR,
      MEMREAD  = ST_MEMREAD,
      MEMWB    = ST_MEMWB,
      MEMWRITE = ST_MEMWRITE,
      EXECUTE  = ST_EXECUTE,
      ALUWB    = ST_ALUWB,
      BRANCH   = ST_BRANCH,
      IMMEX    = ST_IMMEX,
      IMMWB    = ST_IMMWB,
      JUMP     = ST_JUMP,
      TRAP     = ST_TRAP
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;

   localparam logic [1:0] SRCB_REG    = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   // ALU operation class handed from the FSM to the ALU decoder
   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_FUNCT = 2'b10,
      ALUOP_IMM   = 2'b11
   } alu_op_t;

   function automatic logic is_zext_imm(input logic [5:0] op);
      return (op == OP_ANDI) || (op == OP_ORI);
   endfunction

endpackage

// File: rtl/mips_alu_decoder.sv
// Combinational ALU decoder: maps the FSM's ALU operation class plus Funct/Op
// onto a zero-extended ALU control code.
module mips_alu_decoder
   import mips_ctrl_pkg::*;
#(
   parameter int ALU_CTRL_W = 3
) (
   input  alu_op_t               alu_op,
   input  logic [5:0]            funct,
   input  logic [5:0]            op,
   output logic [ALU_CTRL_W-1:0] alu_control
);

   logic [2:0] code;

   always_comb begin
      code = ALU_ADD;
      case (alu_op)
         ALUOP_SUB: code = ALU_SUB;
         ALUOP_FUNCT: begin
            // unknown funct falls back to add rather than trapping
            case (funct)
               FN_SUB:  code = ALU_SUB;
               FN_AND:  code = ALU_AND;
               FN_OR:   code = ALU_OR;
               FN_SLT:  code = ALU_SLT;
               default: code = ALU_ADD;
            endcase
         end
         ALUOP_IMM: begin
            case (op)
               OP_ANDI: code = ALU_AND;
               OP_ORI:  code = ALU_OR;
               OP_SLTI: code = ALU_SLT;
               default: code = ALU_ADD;
            endcase
         end
         default: code = ALU_ADD;
      endcase
   end

   assign alu_control = ALU_CTRL_W'(code);

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control unit: Moore FSM sequencing fetch/decode/execute/
// memory/writeback with optional memory-ready wait and illegal-opcode trap.
//
// state    | meaning
// ---------+-----------------------------------------------
// FETCH    | read instruction, PC += 4 (waits on MemReady)
// DECODE   | register read, branch target into ALUOut
// MEMADR   | lw/sw effective address
// MEMREAD  | load data read (waits on MemReady)
// MEMWB    | load data to register file
// MEMWRITE | store data write (waits on MemReady)
// EXECUTE  | R-type ALU operation
// ALUWB    | R-type result to rd
// BRANCH   | beq/bne compare, conditional PC update
// IMMEX    | immediate ALU operation
// IMMWB    | immediate result to rt
// JUMP     | PC <= jump target
// TRAP     | one-cycle illegal opcode pulse
module mips_multicycle_ctrl
   import mips_ctrl_pkg::*;
#(
   parameter int ALU_CTRL_W    = 3,
   parameter bit HAS_BNE       = 1'b1,
   parameter bit HAS_IMM_LOGIC = 1'b1,
   parameter bit MEM_WAIT      = 1'b0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [5:0]            Op,
   input  logic [5:0]            Funct,
   input  logic                  Zero,
   input  logic                  MemReady,
   output logic                  IorD,
   output logic                  ALUSrcA,
   output logic                  RegDst,
   output logic                  MemtoReg,
   output logic                  IRWrite,
   output logic                  MemWrite,
   output logic                  RegWrite,
   output logic                  Branch,
   output logic                  PCWrite,
   output logic                  ExtOp,
   output logic [1:0]            ALUSrcB,
   output logic [1:0]            PCSrc,
   output logic                  PCEn,
   output logic [ALU_CTRL_W-1:0] ALUControl,
   output logic                  IllegalOp
);

   state_t  state, state_nxt;
   alu_op_t alu_op;
   logic    mem_rdy, is_branch, is_imm, is_bne;
   logic    ir_wr, pc_wr, mem_wr, reg_wr, br, ill;

   assign mem_rdy   = MEM_WAIT ? MemReady : 1'b1;
   assign is_branch = (Op == OP_BEQ) || (HAS_BNE && (Op == OP_BNE));
   assign is_imm    = (Op == OP_ADDI) ||
                      (HAS_IMM_LOGIC && ((Op == OP_ANDI) || (Op == OP_ORI) || (Op == OP_SLTI)));
   assign is_bne    = (Op == OP_BNE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= FETCH;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      alu_op    = ALUOP_ADD;
      IorD      = 1'b0;
      ALUSrcA   = 1'b0;
      RegDst    = 1'b0;
      MemtoReg  = 1'b0;
      ExtOp     = 1'b0;
      ALUSrcB   = SRCB_REG;
      PCSrc     = PCSRC_ALU;
      ir_wr     = 1'b0;
      pc_wr     = 1'b0;
      mem_wr    = 1'b0;
      reg_wr    = 1'b0;
      br        = 1'b0;
      ill       = 1'b0;
      case (state)
         FETCH: begin
            ALUSrcB = SRCB_FOUR;
            if (mem_rdy) begin
               ir_wr     = 1'b1;
               pc_wr     = 1'b1;
               state_nxt = DECODE;
            end
         end
         DECODE: begin
            ALUSrcB = SRCB_IMM_SH;
            if (Op == OP_RTYPE)                   state_nxt = EXECUTE;
            else if ((Op == OP_LW) || (Op == OP_SW)) state_nxt = MEMADR;
            else if (is_branch)                   state_nxt = BRANCH;
            else if (is_imm)                      state_nxt = IMMEX;
            else if (Op == OP_J)                  state_nxt = JUMP;
            else                                  state_nxt = TRAP;
         end
         MEMADR: begin
            ALUSrcA   = 1'b1;
            ALUSrcB   = SRCB_IMM;
            state_nxt = (Op == OP_LW) ? MEMREAD : MEMWRITE;
         end
         MEMREAD: begin
            IorD = 1'b1;
            if (mem_rdy) state_nxt = MEMWB;
         end
         MEMWB: begin
            MemtoReg  = 1'b1;
            reg_wr    = 1'b1;
            state_nxt = FETCH;
         end
         MEMWRITE: begin
            IorD   = 1'b1;
            mem_wr = 1'b1;
            if (mem_rdy) state_nxt = FETCH;
         end
         EXECUTE: begin
            ALUSrcA   = 1'b1;
            alu_op    = ALUOP_FUNCT;
            state_nxt = ALUWB;
         end
         ALUWB: begin
            RegDst    = 1'b1;
            reg_wr    = 1'b1;
            alu_op    = ALUOP_FUNCT;
            state_nxt = FETCH;
         end
         BRANCH: begin
            ALUSrcA   = 1'b1;
            alu_op    = ALUOP_SUB;
            PCSrc     = PCSRC_ALUOUT;
            br        = 1'b1;
            state_nxt = FETCH;
         end
         IMMEX, IMMWB: begin
            ALUSrcA   = 1'b1;
            ALUSrcB   = SRCB_IMM;
            alu_op    = ALUOP_IMM;
            ExtOp     = is_zext_imm(Op);
            reg_wr    = (state == IMMWB);
            state_nxt = (state == IMMEX) ? IMMWB : FETCH;
         end
         JUMP: begin
            PCSrc     = PCSRC_JUMP;
            pc_wr     = 1'b1;
            state_nxt = FETCH;
         end
         TRAP: begin
            ill       = 1'b1;
            state_nxt = FETCH;
         end
         default: state_nxt = FETCH;
      endcase
   end

   // strobes are masked while reset is held so FETCH cannot write IR/PC early
   assign IRWrite   = ir_wr  & rst_n;
   assign PCWrite   = pc_wr  & rst_n;
   assign MemWrite  = mem_wr & rst_n;
   assign RegWrite  = reg_wr & rst_n;
   assign Branch    = br     & rst_n;
   assign IllegalOp = ill    & rst_n;
   assign PCEn      = PCWrite | (Branch & (Zero ^ is_bne));

   mips_alu_decoder #(
      .ALU_CTRL_W (ALU_CTRL_W)
   ) u_alu_decoder (
      .alu_op      (alu_op),
      .funct       (Funct),
      .op          (Op),
      .alu_control (ALUControl)
   );

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench for mips_multicycle_ctrl: a MEM_WAIT=1 instance runs the
// instruction mix, a HAS_BNE=0 instance is released only around the bne trap case.
module tb_mips_multicycle_ctrl;

   // {iord,srca,regdst,memtoreg,irwrite,memwrite,regwrite,branch,pcwrite,extop,
   //  srcb[1:0],pcsrc[1:0],pcen,aluc[2:0],illegal}
   typedef logic [18:0] out_t;

   function automatic out_t e(input logic [9:0] f, input logic [1:0] sb, input logic [1:0] ps,
                              input logic pe, input logic [2:0] ac, input logic il);
      return {f, sb, ps, pe, ac, il};
   endfunction

   localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
   localparam logic [5:0] OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_ORI = 6'b001101, OP_SLTI = 6'b001010, OP_J = 6'b000010;
   localparam logic [5:0] OP_BAD = 6'b111111;

   logic clk = 1'b0;
   logic rst_n, rst2_n;
   logic [5:0] Op, Funct;
   logic Zero, MemReady;

   logic IorD, ALUSrcA, RegDst, MemtoReg, IRWrite, MemWrite, RegWrite, Branch, PCWrite, ExtOp;
   logic [1:0] ALUSrcB, PCSrc;
   logic PCEn, IllegalOp;
   logic [2:0] ALUControl;

   logic iord_2, srca_2, regdst_2, memtoreg_2, irwrite_2, memwrite_2, regwrite_2;
   logic branch_2, pcwrite_2, extop_2, pcen_2, ill_2;
   logic [1:0] srcb_2, pcsrc_2;
   logic [3:0] alu_2;

   int n_checks = 0;
   int n_errors = 0;

   out_t  q_exp[$];
   string q_tag[$];
   logic  q_il2[$];

   out_t  m_exp, m_got;
   string m_tag;
   logic  m_il2;

   always #5 clk = ~clk;

   mips_multicycle_ctrl #(
      .ALU_CTRL_W(3), .HAS_BNE(1'b1), .HAS_IMM_LOGIC(1'b1), .MEM_WAIT(1'b1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .Op(Op), .Funct(Funct), .Zero(Zero), .MemReady(MemReady),
      .IorD(IorD), .ALUSrcA(ALUSrcA), .RegDst(RegDst), .MemtoReg(MemtoReg),
      .IRWrite(IRWrite), .MemWrite(MemWrite), .RegWrite(RegWrite), .Branch(Branch),
      .PCWrite(PCWrite), .ExtOp(ExtOp), .ALUSrcB(ALUSrcB), .PCSrc(PCSrc), .PCEn(PCEn),
      .ALUControl(ALUControl), .IllegalOp(IllegalOp)
   );

   mips_multicycle_ctrl #(
      .ALU_CTRL_W(4), .HAS_BNE(1'b0), .HAS_IMM_LOGIC(1'b1), .MEM_WAIT(1'b0)
   ) dut_nobne (
      .clk(clk), .rst_n(rst2_n), .Op(Op), .Funct(Funct), .Zero(Zero), .MemReady(MemReady),
      .IorD(iord_2), .ALUSrcA(srca_2), .RegDst(regdst_2), .MemtoReg(memtoreg_2),
      .IRWrite(irwrite_2), .MemWrite(memwrite_2), .RegWrite(regwrite_2), .Branch(branch_2),
      .PCWrite(pcwrite_2), .ExtOp(extop_2), .ALUSrcB(srcb_2), .PCSrc(pcsrc_2), .PCEn(pcen_2),
      .ALUControl(alu_2), .IllegalOp(ill_2)
   );

   // drive one cycle of inputs just after the edge and queue what must be seen
   task automatic cyc(input logic [5:0] op, input logic [5:0] fn, input logic z, input logic mr,
                      input out_t ex, input string tag, input logic rn = 1'b1,
                      input logic rn2 = 1'b0, input logic il2 = 1'b0);
      @(posedge clk);
      #1;
      Op = op; Funct = fn; Zero = z; MemReady = mr; rst_n = rn; rst2_n = rn2;
      q_exp.push_back(ex);
      q_tag.push_back(tag);
      q_il2.push_back(il2);
   endtask

   always @(negedge clk) begin
      if (q_exp.size() != 0) begin
         m_exp = q_exp.pop_front();
         m_tag = q_tag.pop_front();
         m_il2 = q_il2.pop_front();
         m_got = {IorD, ALUSrcA, RegDst, MemtoReg, IRWrite, MemWrite, RegWrite, Branch,
                  PCWrite, ExtOp, ALUSrcB, PCSrc, PCEn, ALUControl, IllegalOp};
         n_checks++;
         if (m_got !== m_exp) begin
            n_errors++;
            $display("FAIL %s: outputs got %b required %b", m_tag, m_got, m_exp);
         end
         n_checks++;
         if ({ill_2, alu_2} !== {m_il2, 4'b0010}) begin
            n_errors++;
            $display("FAIL %s/nobne: IllegalOp,ALUControl got %b,%b required %b,0010",
                     m_tag, ill_2, alu_2, m_il2);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      out_t F, FW, D, MA, MR, MWB, MW, TR, J;
      F   = e(10'b0000100010, 2'b01, 2'b00, 1'b1, 3'b010, 1'b0);
      FW  = e(10'b0000000000, 2'b01, 2'b00, 1'b0, 3'b010, 1'b0);
      D   = e(10'b0000000000, 2'b11, 2'b00, 1'b0, 3'b010, 1'b0);
      MA  = e(10'b0100000000, 2'b10, 2'b00, 1'b0, 3'b010, 1'b0);
      MR  = e(10'b1000000000, 2'b00, 2'b00, 1'b0, 3'b010, 1'b0);
      MWB = e(10'b0001001000, 2'b00, 2'b00, 1'b0, 3'b010, 1'b0);
      MW  = e(10'b1000010000, 2'b00, 2'b00, 1'b0, 3'b010, 1'b0);
      J   = e(10'b0000000010, 2'b00, 2'b10, 1'b1, 3'b010, 1'b0);
      TR  = e(10'b0000000000, 2'b00, 2'b00, 1'b0, 3'b010, 1'b1);

      Op = 6'd0; Funct = 6'd0; Zero = 1'b0; MemReady = 1'b1; rst_n = 1'b0; rst2_n = 1'b0;

      cyc(OP_R, 6'd0, 1'b0, 1'b1, FW, "reset0", 1'b0);
      cyc(OP_R, 6'd0, 1'b0, 1'b1, FW, "reset1", 1'b0);

      // R-type sub, and, unknown funct
      cyc(OP_R, 6'b100010, 1'b0, 1'b1, F, "sub.fetch");
      cyc(OP_R, 6'b100010, 1'b0, 1'b1, D, "sub.decode");
      cyc(OP_R, 6'b100010, 1'b0, 1'b1, e(10'b0100000000, 2'b00, 2'b00, 1'b0, 3'b110, 1'b0), "sub.exec");
      cyc(OP_R, 6'b100010, 1'b0, 1'b1, e(10'b0010001000, 2'b00, 2'b00, 1'b0, 3'b110, 1'b0), "sub.wb");
      cyc(OP_R, 6'b100100, 1'b0, 1'b1, F, "and.fetch");
      cyc(OP_R, 6'b100100, 1'b0, 1'b1, D, "and.decode");
      cyc(OP_R, 6'b100100, 1'b0, 1'b1, e(10'b0100000000, 2'b00, 2'b00, 1'b0, 3'b000, 1'b0), "and.exec");
      cyc(OP_R, 6'b100100, 1'b0, 1'b1, e(10'b0010001000, 2'b00, 2'b00, 1'b0, 3'b000, 1'b0), "and.wb");
      cyc(OP_R, 6'b000000, 1'b0, 1'b1, F, "unk.fetch");
      cyc(OP_R, 6'b000000, 1'b0, 1'b1, D, "unk.decode");
      cyc(OP_R, 6'b000000, 1'b0, 1'b1, e(10'b0100000000, 2'b00, 2'b00, 1'b0, 3'b010, 1'b0), "unk.exec");
      cyc(OP_R, 6'b000000, 1'b0, 1'b1, e(10'b0010001000, 2'b00, 2'b00, 1'b0, 3'b010, 1'b0), "unk.wb");

      // lw with two MemReady-low cycles in MEMREAD
      cyc(OP_LW, 6'd0, 1'b0, 1'b1, F,   "lw.fetch");
      cyc(OP_LW, 6'd0, 1'b0, 1'b1, D,   "lw.decode");
      cyc(OP_LW, 6'd0, 1'b0, 1'b1, MA,  "lw.memadr");
      cyc(OP_LW, 6'd0, 1'b0, 1'b0, MR,  "lw.read0");
      cyc(OP_LW, 6'd0, 1'b0, 1'b0, MR,  "lw.read1");
      cyc(OP_LW, 6'd0, 1'b0, 1'b1, MR,  "lw.read2");
      cyc(OP_LW, 6'd0, 1'b0, 1'b1, MWB, "lw.memwb");

      cyc(OP_SW, 6'd0, 1'b0, 1'b1, F,  "sw.fetch");
      cyc(OP_SW, 6'd0, 1'b0, 1'b1, D,  "sw.decode");
      cyc(OP_SW, 6'd0, 1'b0, 1'b1, MA, "sw.memadr");
      cyc(OP_SW, 6'd0, 1'b0, 1'b1, MW, "sw.write");

      // branches
      cyc(OP_BEQ, 6'd0, 1'b1, 1'b1, F, "beqz1.fetch");
      cyc(OP_BEQ, 6'd0, 1'b1, 1'b1, D, "beqz1.decode");
      cyc(OP_BEQ, 6'd0, 1'b1, 1'b1, e(10'b0100000100, 2'b00, 2'b01, 1'b1, 3'b110, 1'b0), "beqz1.branch");
      cyc(OP_BEQ, 6'd0, 1'b0, 1'b1, F, "beqz0.fetch");
      cyc(OP_BEQ, 6'd0, 1'b0, 1'b1, D, "beqz0.decode");
      cyc(OP_BEQ, 6'd0, 1'b0, 1'b1, e(10'b0100000100, 2'b00, 2'b01, 1'b0, 3'b110, 1'b0), "beqz0.branch");
      cyc(OP_BNE, 6'd0, 1'b1, 1'b1, F, "bnez1.fetch",  1'b1, 1'b1, 1'b0);
      cyc(OP_BNE, 6'd0, 1'b1, 1'b1, D, "bnez1.decode", 1'b1, 1'b1, 1'b0);
      cyc(OP_BNE, 6'd0, 1'b1, 1'b1, e(10'b0100000100, 2'b00, 2'b01, 1'b0, 3'b110, 1'b0),
          "bnez1.branch", 1'b1, 1'b1, 1'b1);
      cyc(OP_BNE, 6'd0, 1'b0, 1'b1, F, "bnez0.fetch", 1'b1, 1'b1, 1'b0);
      cyc(OP_BNE, 6'd0, 1'b0, 1'b1, D, "bnez0.decode");
      cyc(OP_BNE, 6'd0, 1'b0, 1'b1, e(10'b0100000100, 2'b00, 2'b01, 1'b1, 3'b110, 1'b0), "bnez0.branch");

      // immediates; addi also exercises a FETCH wait
      cyc(OP_ORI, 6'd0, 1'b0, 1'b1, F, "ori.fetch");
      cyc(OP_ORI, 6'd0, 1'b0, 1'b1, D, "ori.decode");
      cyc(OP_ORI, 6'd0, 1'b0, 1'b1, e(10'b0100000001, 2'b10, 2'b00, 1'b0, 3'b001, 1'b0), "ori.immex");
      cyc(OP_ORI, 6'd0, 1'b0, 1'b1, e(10'b0100001001, 2'b10, 2'b00, 1'b0, 3'b001, 1'b0), "ori.immwb");
      cyc(OP_ADDI, 6'd0, 1'b0, 1'b0, FW, "addi.fetchwait");
      cyc(OP_ADDI, 6'd0, 1'b0, 1'b1, F,  "addi.fetch");
      cyc(OP_ADDI, 6'd0, 1'b0, 1'b1, D,  "addi.decode");
      cyc(OP_ADDI, 6'd0, 1'b0, 1'b1, e(10'b0100000000, 2'b10, 2'b00, 1'b0, 3'b010, 1'b0), "addi.immex");
      cyc(OP_ADDI, 6'd0, 1'b0, 1'b1, e(10'b0100001000, 2'b10, 2'b00, 1'b0, 3'b010, 1'b0), "addi.immwb");
      cyc(OP_SLTI, 6'd0, 1'b0, 1'b1, F, "slti.fetch");
      cyc(OP_SLTI, 6'd0, 1'b0, 1'b1, D, "slti.decode");
      cyc(OP_SLTI, 6'd0, 1'b0, 1'b1, e(10'b0100000000, 2'b10, 2'b00, 1'b0, 3'b111, 1'b0), "slti.immex");
      cyc(OP_SLTI, 6'd0, 1'b0, 1'b1, e(10'b0100001000, 2'b10, 2'b00, 1'b0, 3'b111, 1'b0), "slti.immwb");

      cyc(OP_J, 6'd0, 1'b0, 1'b1, F, "j.fetch");
      cyc(OP_J, 6'd0, 1'b0, 1'b1, D, "j.decode");
      cyc(OP_J, 6'd0, 1'b0, 1'b1, J, "j.jump");

      cyc(OP_BAD, 6'd0, 1'b0, 1'b1, F,  "bad.fetch");
      cyc(OP_BAD, 6'd0, 1'b0, 1'b1, D,  "bad.decode");
      cyc(OP_BAD, 6'd0, 1'b0, 1'b1, TR, "bad.trap");

      // sw stalled in MEMWRITE, then reset pulled mid-access
      cyc(OP_SW, 6'd0, 1'b0, 1'b1, F,  "swrst.fetch");
      cyc(OP_SW, 6'd0, 1'b0, 1'b1, D,  "swrst.decode");
      cyc(OP_SW, 6'd0, 1'b0, 1'b1, MA, "swrst.memadr");
      cyc(OP_SW, 6'd0, 1'b0, 1'b0, MW, "swrst.write0");
      cyc(OP_SW, 6'd0, 1'b0, 1'b0, MW, "swrst.write1");
      cyc(OP_SW, 6'd0, 1'b0, 1'b0, FW, "swrst.inreset0", 1'b0);
      cyc(OP_SW, 6'd0, 1'b0, 1'b1, FW, "swrst.inreset1", 1'b0);
      cyc(OP_SW, 6'd0, 1'b0, 1'b1, F,  "swrst.refetch");
      cyc(OP_SW, 6'd0, 1'b0, 1'b1, D,  "swrst.redecode");

      @(negedge clk);
      #1;
      n_checks++;
      if (q_exp.size() != 0) begin
         n_errors++;
         $display("FAIL drain: %0d expected entries left, required 0", q_exp.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
